// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } piso_state_t;

    function automatic int piso_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_transmitter_counter.sv
// Small up/down counter with synchronous clear (highest priority), load and enable.
module piso_transmitter_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (en) begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in, serial-out frame transmitter: valid/ready word intake, one bit per
// clock with valid/last strobes, per-word bit order and optional idle gap.
module piso_transmitter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             left,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_last,
    output logic             busy
);

    localparam int CNT_W = piso_cnt_w(WIDTH);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_ordered;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             serial_valid_q, serial_valid_d;
    logic             serial_last_q, serial_last_d;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;
    logic             xfer;

    assign last_bit = (state_q == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end else if (last_bit && (GAP == 0)) begin
                in_ready = 1'b1;
            end
        end
    end

    assign xfer = in_valid && in_ready;

    // The shift register always sends from its MSB, so LSB-first words are stored reversed.
    always_comb begin
        word_ordered = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word_ordered[i] = left ? data_in[i] : data_in[WIDTH-1-i];
        end
    end

    piso_transmitter_counter #(
        .WIDTH(CNT_W)
    ) u_bit_cnt (
        .clock     (clock),
        .clear     (reset | last_bit),
        .load      (1'b0),
        .load_value('0),
        .en        (state_q == SHIFT),
        .up        (1'b1),
        .count     (bit_cnt)
    );

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        gap_cnt_d     = gap_cnt_q;
        serial_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHIFT;
                    shreg_d = word_ordered;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    shreg_d = '0;
                    if (GAP > 0) begin
                        state_d   = piso_pkg::GAP;
                        gap_cnt_d = '0;
                    end else if (xfer) begin
                        state_d = SHIFT;
                        shreg_d = word_ordered;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shreg_d       = shreg_q << 1;
                    serial_last_d = (bit_cnt == CNT_W'(WIDTH - 2));
                end
            end
            piso_pkg::GAP: begin
                if (gap_cnt_q == 4'(GAP - 1)) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '0;
            end
        endcase
        serial_valid_d = (state_d == SHIFT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            gap_cnt_q      <= '0;
            serial_valid_q <= 1'b0;
            serial_last_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            gap_cnt_q      <= gap_cnt_d;
            serial_valid_q <= serial_valid_d;
            serial_last_q  <= serial_last_d;
        end
    end

    assign serial_out   = shreg_q[WIDTH-1];
    assign serial_valid = serial_valid_q;
    assign serial_last  = serial_last_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/piso_transmitter.md
Name: piso_transmitter

Overview:
Parallel-in, serial-out frame transmitter. It is the sending end for the ShiftRegisterSIPO deserializer in the component library. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock with a qualifying strobe. Direction is selectable per word, and an optional idle gap is inserted between frames. A ShiftRegisterSIPO with en=serial_valid and a matching `left` reconstructs the word exactly.

Parameters:
WIDTH, 8, word length in bits (>=2)
GAP, 0, idle cycles forced after each frame (0..15)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; forces idle state
data_in  input  WIDTH  parallel word to send
left  input  1  1 = MSB first, 0 = LSB first; sampled with data_in
in_valid  input  1  upstream has a word on data_in
in_ready  output  1  block can accept a word this cycle
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out carries a frame bit this cycle
serial_last  output  1  high with the final bit of a frame
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clock`, `reset`).
- States: IDLE, SHIFT, GAP.
- Reset values (cycle after reset is sampled high):
  - state=IDLE, shift register=0, bit count=0, gap count=0.
  - serial_out=0, serial_valid=0, serial_last=0, busy=0.
  - in_ready=0 while reset is high.
- Handshake: a transfer occurs at a posedge where in_valid & in_ready. data_in and left are captured only then. in_valid without in_ready is ignored and holds no state.
- in_ready, combinational:
  - 1 in IDLE.
  - 1 in SHIFT on the last bit when GAP==0 (back-to-back).
  - 0 otherwise.
- Latency: transfer at edge k → first bit on serial_out during cycle k+1. Bits are valid for cycles k+1..k+WIDTH.
- Outputs serial_out, serial_valid, serial_last are registered. No combinational path from data_in to serial_out.
- Bit order:
  - left=1 → data_in[WIDTH-1] first, down to data_in[0].
  - left=0 → data_in[0] first, up to data_in[WIDTH-1].
- SHIFT transitions:
  - The bit counter runs 0..WIDTH-1. serial_last=1 when count==WIDTH-1.
  - After the last bit, with GAP>0 → GAP.
  - After the last bit, with GAP==0 and a new transfer → stay in SHIFT, count=0, new word's first bit next cycle (no bubble).
  - After the last bit, with GAP==0 and no transfer → IDLE.
- GAP state:
  - Lasts exactly GAP cycles with serial_valid=0 and serial_out=0, then IDLE.
  - in_ready=0 throughout.
- Outside SHIFT: serial_out=0, serial_valid=0, serial_last=0.
- data_in changing mid-frame has no effect on the bits being sent.
- Reset mid-frame: the frame is abandoned. Outputs take reset values the next cycle and no partial word is resent.

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, GAP} piso_state_t
  - localparam function for the bit-counter width, $clog2(WIDTH)
- Bit counter: instantiate the library Counter (WIDTH=$clog2(WIDTH)), driven with clear=reset|last_bit, load=0, up=1.
- Shift register and FSM live in piso_transmitter itself.
- The testbench pairs the block with ShiftRegisterSIPO for loopback checks.

Test Plan:
1. WIDTH=8, GAP=0: reset 2 cycles → in_ready=0 during reset; after it, in_ready=1, serial_valid=0, serial_out=0, busy=0.
2. data_in=8'hC1, left=1, in_valid for 1 cycle at edge k → cycles k+1..k+8 give serial_out 1,1,0,0,0,0,0,1; serial_valid=1; serial_last only at k+8; IDLE at k+9.
3. data_in=8'hC1, left=0 → serial_out 1,0,0,0,0,0,1,1.
4. Back-to-back with GAP=0: words 8'hC1 then 8'h3A, in_valid held → 16 consecutive valid bits; second handshake on the last bit of the first word; no bubble. SIPO loopback (left=1, en=serial_valid) reads 8'hC1 then 8'h3A.
5. GAP=3, two words queued:
   - 3 cycles of serial_valid=0 and in_ready=0 between frames, then one IDLE cycle with in_ready=1.
   - Second frame starts 4 cycles after the first frame's last bit.
6. Reset asserted at bit 4 of 8'hFF → next cycle serial_valid=0, busy=0. A following word 8'h01 (left=1) sends exactly 0,0,0,0,0,0,0,1 with no residue.
